// File: rtl/mux_nto1_skid_pkg.sv
// Shared definitions for the N-to-1 operand selector with skid output stage.
package mux_pkg;

  // Occupancy of the two-entry output stage.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  // Select width for n inputs; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_skid_if.sv
// Handshake bus between the forwarding sources, the selector and the next stage.
interface mux_nto1_skid_if
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 4
);
  localparam int SEL_W = sel_w(N_INPUTS);

  logic [N_INPUTS*WIDTH-1:0] inputs;
  logic [SEL_W-1:0]          select;
  logic                      in_valid;
  logic                      in_ready;
  logic                      flush;
  logic [WIDTH-1:0]          result;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;

  // Upstream/downstream side (driver of operands, consumer of results).
  modport master (
    output inputs, select, in_valid, flush, out_ready,
    input  in_ready, result, out_valid, sel_err
  );

  // Selector block side.
  modport slave (
    input  inputs, select, in_valid, flush, out_ready,
    output in_ready, result, out_valid, sel_err
  );
endinterface

// File: rtl/mux_nto1_skid_sel.sv
// Purely combinational N-to-1 selector; out-of-range selects fall back to the
// last input and raise err.
module mux_nto1
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 4
) (
  input  logic [N_INPUTS*WIDTH-1:0]    inputs,
  input  logic [sel_w(N_INPUTS)-1:0]   sel,
  output logic [WIDTH-1:0]             data,
  output logic                         err
);
  localparam int SEL_W = sel_w(N_INPUTS);
  localparam logic [SEL_W:0] N_CNT = (SEL_W+1)'(N_INPUTS);

  // Default to the last input so an out-of-range index still yields defined data.
  always_comb begin
    data = inputs[(N_INPUTS-1)*WIDTH +: WIDTH];
    err  = ({1'b0, sel} >= N_CNT);
    for (int k = 0; k < N_INPUTS; k++)
      if ({1'b0, sel} == (SEL_W+1)'(k)) data = inputs[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/mux_nto1_skid.sv
// N-to-1 operand selector with a registered two-entry skid output stage.
// in_ready depends only on the state register, so back-pressure never forms a
// combinational path from out_ready to in_ready.
module mux_nto1_skid
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_nto1_skid_if.slave bus
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_data, skid_data, sel_data;
  logic             main_err, skid_err, sel_err_c;
  logic             accept, consume, load_main, load_skid, shift;

  mux_nto1 #(.WIDTH(WIDTH), .N_INPUTS(N_INPUTS)) u_sel (
    .inputs (bus.inputs),
    .sel    (bus.select),
    .data   (sel_data),
    .err    (sel_err_c)
  );

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.result    = main_data;
  // A flushed or drained main register may still hold a stale error bit.
  assign bus.sel_err   = main_err & (state != EMPTY);

  assign accept  = bus.in_valid  & bus.in_ready;
  assign consume = bus.out_valid & bus.out_ready;

  // Next-state and register-load decode; flush overrides everything.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    shift     = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (consume) begin
          shift     = 1'b1;
          state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Main and skid entries; main is refilled from the mux or from skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data <= sel_data;
        main_err  <= sel_err_c;
      end else if (shift) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err_c;
      end
    end
  end
endmodule

// File: tb/tb_mux_nto1_skid.sv
// Directed bench for mux_nto1_skid: a 4-input 32-bit instance and a 3-input
// 8-bit instance for the out-of-range select path.
module tb_mux_nto1_skid;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_nto1_skid_if #(.WIDTH(32), .N_INPUTS(4)) b4 ();
  mux_nto1_skid_if #(.WIDTH(8),  .N_INPUTS(3)) b3 ();

  mux_nto1_skid #(.WIDTH(32), .N_INPUTS(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mux_nto1_skid #(.WIDTH(8),  .N_INPUTS(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.inputs = {32'h44, 32'h33, 32'h22, 32'h11};
    b4.select = '0; b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b0;
    b3.inputs = {8'hC3, 8'hB2, 8'hA1};
    b3.select = '0; b3.in_valid = 1'b0; b3.flush = 1'b0; b3.out_ready = 1'b0;
    #1;
    n_chk++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); end
    n_chk++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", b4.in_ready); end
    n_chk++; if (b4.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", b4.result); end
    n_chk++; if (b4.sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b want 0", b4.sel_err); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    b4.out_ready = 1'b1;
    b4.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.select = 2'(i);
      cyc();
      exp = 32'h11 * (i + 1);
      n_chk++; if (b4.result !== exp) begin n_fail++; $display("FAIL stream_result[%0d]: got %h want %h", i, b4.result, exp); end
      n_chk++; if (b4.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d]: got %b want 1", i, b4.out_valid); end
      n_chk++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, b4.in_ready); end
    end
    b4.in_valid = 1'b0;
    cyc();
    n_chk++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", b4.out_valid); end
  endtask

  task automatic test_back_pressure();
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.select    = 2'd1;
    cyc();
    n_chk++; if (b4.result !== 32'h22) begin n_fail++; $display("FAIL bp_first: got %h want 22", b4.result); end
    n_chk++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b want 1", b4.in_ready); end
    b4.select = 2'd2;
    cyc();
    n_chk++; if (b4.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", b4.in_ready); end
    n_chk++; if (b4.result !== 32'h22) begin n_fail++; $display("FAIL bp_hold: got %h want 22", b4.result); end
    // Offered while full; must not be captured.
    b4.select = 2'd3;
    cyc();
    n_chk++; if (b4.result !== 32'h22) begin n_fail++; $display("FAIL bp_hold2: got %h want 22", b4.result); end
    n_chk++; if (b4.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full2: got %b want 0", b4.in_ready); end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    cyc();
    n_chk++; if (b4.result !== 32'h33) begin n_fail++; $display("FAIL bp_second: got %h want 33", b4.result); end
    n_chk++; if (b4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_second: got %b want 1", b4.out_valid); end
    n_chk++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release: got %b want 1", b4.in_ready); end
    cyc();
    n_chk++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", b4.out_valid); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp_d [3];
    logic       exp_e [3];
    logic [1:0] sels  [3];
    sels  = '{2'd3, 2'd1, 2'd2};
    exp_d = '{8'hC3, 8'hB2, 8'hC3};
    exp_e = '{1'b1, 1'b0, 1'b0};
    b3.out_ready = 1'b1;
    b3.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b3.select = sels[i];
      cyc();
      n_chk++; if (b3.result !== exp_d[i]) begin n_fail++; $display("FAIL oor_result[%0d]: got %h want %h", i, b3.result, exp_d[i]); end
      n_chk++; if (b3.sel_err !== exp_e[i]) begin n_fail++; $display("FAIL oor_sel_err[%0d]: got %b want %b", i, b3.sel_err, exp_e[i]); end
    end
    b3.in_valid = 1'b0;
    cyc();
    n_chk++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL oor_drain: got %b want 0", b3.out_valid); end
  endtask

  task automatic test_flush();
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.select    = 2'd0;
    cyc();
    b4.select = 2'd1;
    cyc();
    n_chk++; if (b4.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_setup_full: got %b want 0", b4.in_ready); end
    b4.select = 2'd3;
    b4.flush  = 1'b1;
    cyc();
    n_chk++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", b4.out_valid); end
    n_chk++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", b4.in_ready); end
    n_chk++; if (b4.sel_err !== 1'b0) begin n_fail++; $display("FAIL flush_sel_err: got %b want 0", b4.sel_err); end
    b4.flush    = 1'b0;
    b4.in_valid = 1'b0;
    cyc();
    n_chk++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_capture: got %b want 0", b4.out_valid); end
  endtask

  task automatic test_reset_mid();
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.select    = 2'd0;
    cyc();
    b4.select = 2'd1;
    cyc();
    n_chk++; if (b4.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_setup_full: got %b want 0", b4.in_ready); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", b4.out_valid); end
    n_chk++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", b4.in_ready); end
    n_chk++; if (b4.result !== 32'h0) begin n_fail++; $display("FAIL rmid_result: got %h want 0", b4.result); end
    // in_valid stays high across an edge under reset; nothing may be taken.
    cyc();
    n_chk++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_held: got %b want 0", b4.out_valid); end
    #2 rst = 1'b0;
    b4.select    = 2'd2;
    b4.out_ready = 1'b1;
    cyc();
    n_chk++; if (b4.result !== 32'h33) begin n_fail++; $display("FAIL rmid_first_after: got %h want 33", b4.result); end
    n_chk++; if (b4.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_after: got %b want 1", b4.out_valid); end
    b4.in_valid = 1'b0;
    cyc();
  endtask

  // Random valid/ready/flush traffic against a queue model of the two entries.
  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp;
    logic        acc, cons;
    b4.flush = 1'b1; b4.in_valid = 1'b0;
    cyc();
    b4.flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      b4.in_valid  = ($urandom_range(0, 3) != 0);
      b4.out_ready = ($urandom_range(0, 2) != 0);
      b4.flush     = ($urandom_range(0, 19) == 0);
      b4.select    = 2'($urandom_range(0, 3));
      acc  = b4.in_valid && (q.size() < 2);
      cons = b4.out_ready && (q.size() > 0);
      exp  = 32'h11 * (32'(b4.select) + 1);
      if (b4.flush) q.delete();
      else begin
        if (cons) void'(q.pop_front());
        if (acc)  q.push_back(exp);
      end
      cyc();
      n_chk++; if (b4.out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, b4.out_valid, q.size() != 0); end
      n_chk++; if (b4.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, b4.in_ready, q.size() < 2); end
      if (q.size() != 0) begin
        n_chk++; if (b4.result !== q[0]) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h want %h", i, b4.result, q[0]); end
      end
    end
    b4.in_valid = 1'b0; b4.flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_out_of_range();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
